// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional feature macro: REG_FILE_MP_BYPASS_EN (write-to-read bypass).
package reg_file_pkg;

  // Clear-sequencer states.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Address width for a register count; never less than one bit.
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write bus of the multi-port register file.
// Optional feature macro: REG_FILE_MP_BYPASS_EN (changes read timing only).
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumRegs   = 32,
  parameter int NumRead   = 2,
  parameter int NumWrite  = 2
);
  localparam int AddrW = addr_width(NumRegs);

  logic [NumRead-1:0][AddrW-1:0]      i_rreg;
  logic [NumRead-1:0][DataWidth-1:0]  o_rdata;
  logic [NumWrite-1:0][AddrW-1:0]     i_wreg;
  logic [NumWrite-1:0][DataWidth-1:0] i_wdata;
  logic [NumWrite-1:0]                i_we;
  logic                               i_clear;
  logic                               o_ready;
  logic                               o_wr_collision;

  modport master (
    output i_rreg, i_wreg, i_wdata, i_we, i_clear,
    input  o_rdata, o_ready, o_wr_collision
  );

  modport slave (
    input  i_rreg, i_wreg, i_wdata, i_we, i_clear,
    output o_rdata, o_ready, o_wr_collision
  );
endinterface

// File: rtl/reg_file_mp_clear_seq.sv
// Clear sequencer: walks every address once after reset or on request,
// then holds READY until the next clear request.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_CLEAR | writing the clear value to address cnt, one per cycle
//   ST_READY | file accepts writes and returns stored data
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int NumRegs = 32,
  parameter int AddrW   = addr_width(NumRegs)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  output logic             o_clr_active,
  output logic [AddrW-1:0] o_clr_addr,
  output logic             o_ready
);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(NumRegs - 1);

  clr_state_e       r_state;
  logic [AddrW-1:0] r_cnt;
  logic             r_clr_active;
  logic             r_ready;

  // State, counter and registered status flags advance together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= '0;
      r_clr_active <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LastAddr) begin
            r_state      <= ST_READY;
            r_cnt        <= '0;
            r_clr_active <= 1'b0;
            r_ready      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (i_clear) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_clr_active <= 1'b1;
            r_ready      <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_CLEAR;
          r_cnt        <= '0;
          r_clr_active <= 1'b1;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_active = r_clr_active;
  assign o_clr_addr   = r_cnt;
  assign o_ready      = r_ready;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with a sequenced clear, highest-port-wins
// write arbitration and a registered same-address collision flag.
// Optional feature macro: REG_FILE_MP_BYPASS_EN -- reads see the data of a
// matching enabled write port in the same cycle instead of one cycle later.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int                   DataWidth  = 32,
  parameter int                   NumRegs    = 32,
  parameter int                   NumRead    = 2,
  parameter int                   NumWrite   = 2,
  parameter int                   ZeroReg    = 1,
  parameter logic [DataWidth-1:0] ClearValue = '0
) (
  input logic         i_clk,
  input logic         i_rst,
  reg_file_mp_if.slave bus
);

  localparam int AddrW = addr_width(NumRegs);

  logic [DataWidth-1:0]              r_regs [NumRegs];
  logic                              r_wr_collision;
  logic                              w_clr_active;
  logic [AddrW-1:0]                  w_clr_addr;
  logic                              w_ready;
  logic                              w_wr_allow;
  logic                              w_collision;
  logic [NumRead-1:0][DataWidth-1:0] w_rdata;

  // Address 0 is a constant zero when ZeroReg is set.
  function automatic logic is_zero_addr(input logic [AddrW-1:0] a);
    return (ZeroReg != 0) && (a == '0);
  endfunction

  reg_file_clear_seq #(
    .NumRegs (NumRegs)
  ) u_clear_seq (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (bus.i_clear),
    .o_clr_active (w_clr_active),
    .o_clr_addr   (w_clr_addr),
    .o_ready      (w_ready)
  );

  // A clear request (or reset) in the same cycle drops the writes.
  assign w_wr_allow = w_ready && !bus.i_clear && !i_rst;

  // Storage: clear walk has priority; later write ports override earlier ones.
  always_ff @(posedge i_clk) begin
    if (w_clr_active) begin
      if (!is_zero_addr(w_clr_addr)) r_regs[w_clr_addr] <= ClearValue;
    end else if (w_wr_allow) begin
      for (int w = 0; w < NumWrite; w++) begin
        if (bus.i_we[w] && !is_zero_addr(bus.i_wreg[w])) begin
          r_regs[bus.i_wreg[w]] <= bus.i_wdata[w];
        end
      end
    end
  end

  // Detect any pair of accepted writes aiming at the same real register.
  always_comb begin
    w_collision = 1'b0;
    for (int i = 0; i < NumWrite; i++) begin
      for (int j = i + 1; j < NumWrite; j++) begin
        if (w_wr_allow && bus.i_we[i] && bus.i_we[j] &&
            (bus.i_wreg[i] == bus.i_wreg[j]) && !is_zero_addr(bus.i_wreg[i])) begin
          w_collision = 1'b1;
        end
      end
    end
  end

  // Collision flag is a one-cycle registered pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wr_collision <= 1'b0;
    else       r_wr_collision <= w_collision;
  end

  // Read ports: zero during clear and for the hardwired zero register.
  always_comb begin
    for (int r = 0; r < NumRead; r++) begin
      w_rdata[r] = '0;
      if (!w_clr_active && !is_zero_addr(bus.i_rreg[r])) begin
        w_rdata[r] = r_regs[bus.i_rreg[r]];
`ifdef REG_FILE_MP_BYPASS_EN
        for (int w = 0; w < NumWrite; w++) begin
          if (w_ready && bus.i_we[w] && (bus.i_wreg[w] == bus.i_rreg[r])) begin
            w_rdata[r] = bus.i_wdata[w];
          end
        end
`endif
      end
    end
  end

  assign bus.o_rdata        = w_rdata;
  assign bus.o_ready        = w_ready;
  assign bus.o_wr_collision = r_wr_collision;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp with default parameters.
// Expectations adapt to REG_FILE_MP_BYPASS_EN when it is defined.
module tb_reg_file_mp;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n;

  reg_file_mp_if #(
    .DataWidth (32),
    .NumRegs   (32),
    .NumRead   (2),
    .NumWrite  (2)
  ) bus ();

  reg_file_mp dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_we    = '0;
    bus.i_clear = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.i_we[p]    = 1'b1;
    bus.i_wreg[p]  = 5'(a);
    bus.i_wdata[p] = d;
  endtask

  task automatic rd_chk(input string tag, input int p, input int a, input logic [31:0] exp);
    bus.i_rreg[p] = 5'(a);
    #1;
    chk(tag, bus.o_rdata[p], exp);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!bus.o_ready && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.i_rreg  = '0;
    bus.i_wreg  = '0;
    bus.i_wdata = '0;
    idle();
    step(); step(); step();
    chk("rst_ready", bus.o_ready, 1'b0);
    chk("rst_coll", bus.o_wr_collision, 1'b0);

    // Clear sequence after reset: 32 cycles low, then ready.
    rst = 1'b0;
    #1;
    chk("ready_low_after_rst", bus.o_ready, 1'b0);
    wait_ready(n);
    chk("ready_rise_cycles", n, 32);
    rd_chk("init_r1", 0, 1, 32'h0);
    rd_chk("init_r31", 1, 31, 32'h0);

    // Single write, reg 5.
    wr(0, 5, 32'hDEAD_BEEF);
    bus.i_rreg[1] = 5'd5;
`ifdef REG_FILE_MP_BYPASS_EN
    rd_chk("wr5_same_cycle", 0, 5, 32'hDEAD_BEEF);
`else
    rd_chk("wr5_same_cycle", 0, 5, 32'h0);
`endif
    step();
    idle();
    rd_chk("wr5_next_cycle", 0, 5, 32'hDEAD_BEEF);
    rd_chk("wr5_port1", 1, 5, 32'hDEAD_BEEF);
    chk("wr5_no_coll", bus.o_wr_collision, 1'b0);

    // Both ports write reg 7: port 1 wins, collision pulse.
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
`ifdef REG_FILE_MP_BYPASS_EN
    rd_chk("coll_bypass", 0, 7, 32'h22);
`else
    rd_chk("coll_bypass", 0, 7, 32'h0);
`endif
    step();
    idle();
    #1;
    chk("coll_pulse", bus.o_wr_collision, 1'b1);
    rd_chk("coll_winner", 0, 7, 32'h22);
    step();
    chk("coll_drop", bus.o_wr_collision, 1'b0);

    // Distinct addresses on both ports, read both ports at once.
    wr(0, 9, 32'hA1A1_0009);
    wr(1, 10, 32'hB2B2_0010);
    step();
    idle();
    chk("dist_no_coll", bus.o_wr_collision, 1'b0);
    rd_chk("dist_r9", 0, 9, 32'hA1A1_0009);
    rd_chk("dist_r10", 1, 10, 32'hB2B2_0010);
    rd_chk("same_addr_p0", 0, 10, 32'hB2B2_0010);
    rd_chk("same_addr_p1", 1, 10, 32'hB2B2_0010);

    // Register 0 is hardwired: writes dropped, no collision.
    wr(0, 0, 32'h1234);
    wr(1, 0, 32'h5678);
    rd_chk("zero_same_cycle", 0, 0, 32'h0);
    step();
    idle();
    rd_chk("zero_after", 0, 0, 32'h0);
    chk("zero_no_coll", bus.o_wr_collision, 1'b0);

    // Preload reg 3 and reg 20, then clear with a coincident write to reg 3.
    wr(0, 3, 32'h99);
    wr(1, 20, 32'h2020);
    step();
    idle();
    rd_chk("pre_r3", 0, 3, 32'h99);
    wr(0, 3, 32'h55);
    bus.i_clear = 1'b1;
    step();
    chk("clear_ready_low", bus.o_ready, 1'b0);
    rd_chk("clear_rdata_forced", 1, 9, 32'h0);
    // Hold clear and a stray write through the whole walk; both must be ignored.
    wr(0, 20, 32'h77);
    n = 0;
    while (!bus.o_ready && n < 100) begin
      step();
      n++;
    end
    idle();
    chk("clear_cycles", n, 32);
    rd_chk("clear_r3", 0, 3, 32'h0);
    rd_chk("clear_r20", 1, 20, 32'h0);
    rd_chk("clear_r5", 0, 5, 32'h0);
    rd_chk("clear_r9", 1, 9, 32'h0);
    step();
    chk("clear_no_restart", bus.o_ready, 1'b1);

    // Reset in the middle of a clear walk restarts it.
    wr(0, 25, 32'hCAFE);
    step();
    idle();
    rd_chk("pre_r25", 0, 25, 32'hCAFE);
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    repeat (10) step();
    chk("mid_clear_low", bus.o_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    wait_ready(n);
    chk("rst_mid_cycles", n, 32);
    rd_chk("rst_mid_r25", 0, 25, 32'h0);

    // Normal operation resumes.
    wr(1, 31, 32'h0BAD_F00D);
    step();
    idle();
    rd_chk("post_r31", 1, 31, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
